// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master: burst/response encodings,
// FSM state types and the AxSIZE helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_e;

  // AxSIZE encoding: log2 of the bus width in bytes.
  function automatic logic [2:0] size_from_width(input int unsigned width);
    int unsigned bytes;
    logic [2:0]  size;
    bytes = width / 8;
    size  = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

  function automatic logic resp_is_err(input resp_e resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axi_master_burst_rd.sv
// Read path of the AXI4 burst master: issues one AR per request and passes
// R beats straight through to the user with full backpressure.
module axi_master_burst_rd
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rreq_valid,
  output logic                  rreq_ready,
  input  logic [ADDR_WIDTH-1:0] rreq_addr,
  input  logic [LEN_WIDTH-1:0]  rreq_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_err,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [LEN_WIDTH-1:0]  ar_len,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  input  logic                  r_valid,
  output logic                  r_ready
);

  typedef logic [LEN_WIDTH:0] cnt_t;

  r_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  cnt_t                  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rreq_ready = 1'b0;
    ar_valid   = 1'b0;
    ar_addr    = '0;
    ar_len     = '0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    rd_err     = 1'b0;
    r_ready    = 1'b0;

    unique case (state_q)
      R_IDLE: begin
        rreq_ready = rst_n;
        if (rreq_valid) begin
          addr_d  = rreq_addr;
          len_d   = rreq_len;
          cnt_d   = '0;
          state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        ar_valid = 1'b1;
        ar_addr  = addr_q;
        ar_len   = len_q;
        if (ar_ready) state_d = R_DATA;
      end
      R_DATA: begin
        rd_valid = r_valid;
        r_ready  = rd_ready;
        rd_data  = r_data;
        rd_last  = r_last;
        rd_err   = resp_is_err(resp_e'(r_resp));
        if (r_valid && rd_ready) begin
          cnt_d = cnt_q + cnt_t'(1);
          if (r_last) state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // The slave must end the burst exactly on the requested beat count.
  a_rlast_on_len: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == R_DATA && r_valid && rd_ready && r_last) |-> (cnt_q == cnt_t'(len_q)));

endmodule

// File: rtl/axi_master_burst.sv
// AXI4 burst master: write FSM lives here, the independent read FSM is the
// axi_master_burst_rd instance.
module axi_master_burst
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    WREQ_VALID,
  output logic                    WREQ_READY,
  input  logic [ADDR_WIDTH-1:0]   WREQ_ADDR,
  input  logic [LEN_WIDTH-1:0]    WREQ_LEN,
  input  logic                    WD_VALID,
  output logic                    WD_READY,
  input  logic [DATA_WIDTH-1:0]   WD_DATA,
  input  logic [DATA_WIDTH/8-1:0] WD_STRB,
  output logic                    WDONE,
  output logic                    WERR,
  input  logic                    RREQ_VALID,
  output logic                    RREQ_READY,
  input  logic [ADDR_WIDTH-1:0]   RREQ_ADDR,
  input  logic [LEN_WIDTH-1:0]    RREQ_LEN,
  output logic                    RD_VALID,
  input  logic                    RD_READY,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic                    RD_LAST,
  output logic                    RD_ERR,
  output logic [ADDR_WIDTH-1:0]   AW_ADDR,
  output logic [LEN_WIDTH-1:0]    AW_LEN,
  output logic [2:0]              AW_SIZE,
  output logic [1:0]              AW_BURST,
  output logic                    AW_VALID,
  input  logic                    AW_READY,
  output logic [DATA_WIDTH-1:0]   W_DATA,
  output logic [DATA_WIDTH/8-1:0] W_STRB,
  output logic                    W_LAST,
  output logic                    W_VALID,
  input  logic                    W_READY,
  input  logic [1:0]              B_RESP,
  input  logic                    B_VALID,
  output logic                    B_READY,
  output logic [ADDR_WIDTH-1:0]   AR_ADDR,
  output logic [LEN_WIDTH-1:0]    AR_LEN,
  output logic [2:0]              AR_SIZE,
  output logic [1:0]              AR_BURST,
  output logic                    AR_VALID,
  input  logic                    AR_READY,
  input  logic [DATA_WIDTH-1:0]   R_DATA,
  input  logic [1:0]              R_RESP,
  input  logic                    R_LAST,
  input  logic                    R_VALID,
  output logic                    R_READY
);

  localparam logic [2:0] AX_SIZE = size_from_width(DATA_WIDTH);

  // One spare bit so the count can step past len without wrapping at 256 beats.
  typedef logic [LEN_WIDTH:0] cnt_t;

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [LEN_WIDTH-1:0]  w_len_q, w_len_d;
  cnt_t                  w_cnt_q, w_cnt_d;
  logic                  aw_done_q, aw_done_d;
  logic                  wdone_q, wdone_d;
  logic                  werr_q, werr_d;
  logic                  beats_left;

  assign AW_SIZE  = AX_SIZE;
  assign AW_BURST = AXI_BURST_INCR;
  assign AR_SIZE  = AX_SIZE;
  assign AR_BURST = AXI_BURST_INCR;
  assign WDONE    = wdone_q;
  assign WERR     = werr_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      aw_done_q <= 1'b0;
      wdone_q   <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      aw_done_q <= aw_done_d;
      wdone_q   <= wdone_d;
      werr_q    <= werr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    aw_done_d  = aw_done_q;
    wdone_d    = 1'b0;
    werr_d     = 1'b0;
    WREQ_READY = 1'b0;
    AW_VALID   = 1'b0;
    AW_ADDR    = '0;
    AW_LEN     = '0;
    W_VALID    = 1'b0;
    WD_READY   = 1'b0;
    W_DATA     = '0;
    W_STRB     = '0;
    W_LAST     = 1'b0;
    B_READY    = 1'b0;
    beats_left = (w_cnt_q <= cnt_t'(w_len_q));

    unique case (w_state_q)
      W_IDLE: begin
        WREQ_READY = RESETN;
        if (WREQ_VALID) begin
          w_addr_d  = WREQ_ADDR;
          w_len_d   = WREQ_LEN;
          w_cnt_d   = '0;
          aw_done_d = 1'b0;
          w_state_d = W_XFER;
        end
      end
      W_XFER: begin
        AW_VALID = !aw_done_q;
        AW_ADDR  = w_addr_q;
        AW_LEN   = w_len_q;
        W_VALID  = WD_VALID && beats_left;
        WD_READY = W_READY && beats_left;
        if (beats_left) begin
          W_DATA = WD_DATA;
          W_STRB = WD_STRB;
          W_LAST = (w_cnt_q == cnt_t'(w_len_q));
        end
        if (W_VALID && W_READY) w_cnt_d = w_cnt_q + cnt_t'(1);
        if (AW_VALID && AW_READY) aw_done_d = 1'b1;
        // Address and data phases may finish in either order or together.
        if (aw_done_d && (w_cnt_d > cnt_t'(w_len_q))) w_state_d = W_RESP;
      end
      W_RESP: begin
        B_READY = 1'b1;
        if (B_VALID) begin
          wdone_d   = 1'b1;
          werr_d    = resp_is_err(resp_e'(B_RESP));
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  axi_master_burst_rd #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_rd (
    .clk       (CLK),
    .rst_n     (RESETN),
    .rreq_valid(RREQ_VALID),
    .rreq_ready(RREQ_READY),
    .rreq_addr (RREQ_ADDR),
    .rreq_len  (RREQ_LEN),
    .rd_valid  (RD_VALID),
    .rd_ready  (RD_READY),
    .rd_data   (RD_DATA),
    .rd_last   (RD_LAST),
    .rd_err    (RD_ERR),
    .ar_addr   (AR_ADDR),
    .ar_len    (AR_LEN),
    .ar_valid  (AR_VALID),
    .ar_ready  (AR_READY),
    .r_data    (R_DATA),
    .r_resp    (R_RESP),
    .r_last    (R_LAST),
    .r_valid   (R_VALID),
    .r_ready   (R_READY)
  );

endmodule
